// File: rtl/gate_arbiter_if.sv
// Handshake bundle between the gate clients, the shared gate datapath arbiter
// and the result consumer. Flat per-requester slices: requester i owns slice i.
interface gate_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [WIDTH-1:0]       rsp_y;

  // master: requesters plus result consumer; slave: the arbiter
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/gate_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (NOT/AND/OR/XOR) between
// N_REQ requesters, with a single skid-free output register.
module gate_arbiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  always_comb begin
    unique case (op_i)
      2'b00:   y_o = ~a_i;
      2'b01:   y_o = a_i & b_i;
      2'b10:   y_o = a_i | b_i;
      default: y_o = a_i ^ b_i;
    endcase
  end
endmodule

module gate_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  gate_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                      state_q;
  logic [IDW-1:0]              ptr_q, ptr_d;
  logic [IDW-1:0]              id_q;
  logic [WIDTH-1:0]            y_q, y_d;
  logic [N_REQ-1:0][WIDTH-1:0] lane_y;
  logic [N_REQ-1:0]            grant_oh;
  logic [IDW-1:0]              grant_idx;
  logic                        grant_any;
  logic                        can_accept;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_lane
      gate_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
        .op_i (bus.req_op[2*g +: 2]),
        .a_i  (bus.req_a[g*WIDTH +: WIDTH]),
        .b_i  (bus.req_b[g*WIDTH +: WIDTH]),
        .y_o  (lane_y[g])
      );
    end
  endgenerate

  // Drain and refill in the same cycle keeps throughput at one op per cycle.
  assign can_accept = (state_q == EMPTY) || bus.rsp_ready;

  always_comb begin
    int idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!grant_any && can_accept && !reset && bus.req_valid[idx]) begin
        grant_any     = 1'b1;
        grant_idx     = IDW'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    y_d   = lane_y[grant_idx];
    ptr_d = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      y_q     <= '0;
    end else begin
      if (grant_any) begin
        ptr_q <= ptr_d;
        id_q  <= grant_idx;
        y_q   <= y_d;
      end
      unique case (state_q)
        EMPTY:   if (grant_any) state_q <= FULL;
        FULL:    if (bus.rsp_ready && !grant_any) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = y_q;
endmodule

// File: tb/tb_gate_arbiter.sv
// Scoreboard bench for gate_arbiter: a round-robin reference model predicts
// grants and results; a separate monitor checks every presented result.
module tb_gate_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]        v;
  logic [N-1:0][1:0]   op;
  logic [N-1:0][W-1:0] a, b;
  logic                rr;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q[$];
  int   ptr_m;
  bit   full_m;
  int   granted;

  gate_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  assign bus.req_valid = v;
  assign bus.req_op    = op;
  assign bus.req_a     = a;
  assign bus.req_b     = b;
  assign bus.rsp_ready = rr;

  gate_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      2'd0:    return ~x;
      2'd1:    return x & y;
      2'd2:    return x | y;
      default: return x ^ y;
    endcase
  endfunction

  // One clock: check the grant decision at the negedge, advance the model,
  // then return just after the following posedge so the caller can restimulate.
  task automatic step();
    int   eg;
    int   idx;
    exp_t e;
    @(negedge clk);
    eg = -1;
    if (!full_m || rr)
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (eg < 0 && v[idx]) eg = idx;
      end
    chk("req_ready", 32'(bus.req_ready), (eg >= 0) ? (32'd1 << eg) : 32'd0);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(full_m));
    if (eg >= 0) begin
      e.id = 2'(eg);
      e.y  = ref_op(op[eg], a[eg], b[eg]);
      q.push_back(e);
      ptr_m  = (eg + 1) % N;
      full_m = 1'b1;
    end else if (full_m && rr) begin
      full_m = 1'b0;
    end
    granted = eg;
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    v[i]  = 1'($urandom_range(0, 1));
    op[i] = 2'($urandom_range(0, 3));
    a[i]  = W'($urandom);
    b[i]  = W'($urandom);
  endtask

  // Monitor: the head of the queue must be on the output for every cycle it is held.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
        chk("rsp_y",  32'(bus.rsp_y),  32'(q[0].y));
        if (bus.rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    v = '1; op = '0; a = '0; b = '0; rr = 1'b0;
    ptr_m = 0; full_m = 1'b0; granted = -1;
    #12;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("reset_rsp_y",     32'(bus.rsp_y),     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    v = '0;

    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_rsp_y", 32'(bus.rsp_y), 32'd0);
    end

    // Single NOT from requester 2.
    rr = 1'b1; v = 4'b0100; op[2] = 2'b00; a[2] = 8'hA5;
    step();
    v = '0;
    step();
    step();

    // All four ops from requester 0, back to back.
    v = 4'b0001; a[0] = 8'hF0; b[0] = 8'h3C;
    for (int o = 0; o < 4; o++) begin
      op[0] = 2'(o);
      step();
    end
    v = '0;
    step();

    // Round-robin with all requesters continuously valid.
    v = '1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (granted >= 0) begin
        op[granted] = 2'($urandom_range(0, 3));
        a[granted]  = W'($urandom);
        b[granted]  = W'($urandom);
      end
    end

    // Backpressure: grant requester 0 so the pointer sits at 1, then stall.
    v = 4'b0001; op[0] = 2'b11; a[0] = 8'h12; b[0] = 8'h34;
    step();
    v = 4'b1010; rr = 1'b0;
    op[1] = 2'b01; a[1] = 8'hCC; b[1] = 8'h0F;
    op[3] = 2'b10; a[3] = 8'h81; b[3] = 8'h18;
    for (int c = 0; c < 3; c++) step();
    rr = 1'b1;
    step();
    v = 4'b1000;
    step();
    v = '0;
    step();

    // Reset while a result is pending, between clock edges.
    v = 4'b0001; rr = 1'b0;
    step();
    v = 4'b1010;
    reset = 1'b1;
    #2;
    chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midreset_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    q.delete();
    full_m = 1'b0;
    ptr_m  = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    rr = 1'b1;
    step();
    v = '0;
    step();

    // Random traffic with random consumer backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (granted == i || !v[i]) new_req(i);
      rr = ($urandom_range(0, 3) != 0);
      step();
    end

    v = '0; rr = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("drain_queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
